// File: rtl/uart_rx.sv
// 8N1 UART receiver. It runs from a 16x oversample tick, samples each bit at its midpoint
// and emits one-cycle strobes for a good byte or for a stop-bit framing error.
module uart_rx #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OS_RATE     = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_x16,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned OS_W = $clog2(OS_RATE);
  localparam int unsigned BC_W = $clog2(DATA_BITS + 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OS_RATE - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OS_RATE / 2 - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_baud_q;
  logic [OS_W-1:0]        r_os_cnt;
  logic [BC_W-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_ferr;
  logic                   r_busy;
  logic                   w_tick;
  logic                   w_rxd_s;

  assign w_tick     = baud_x16 & ~r_baud_q;
  assign w_rxd_s    = r_sync[SYNC_STAGES-1];
  assign data       = r_data;
  assign data_valid = r_valid;
  assign frame_err  = r_ferr;
  assign busy       = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '1;
      r_baud_q <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], rxd};
      r_baud_q <= baud_x16;
    end
  end

  // busy is kept as its own flop, updated alongside every state change, so it stays registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      if (w_tick) begin
        case (r_state)
          IDLE: begin
            if (!w_rxd_s) begin
              r_state  <= START;
              r_os_cnt <= '0;
              r_busy   <= 1'b1;
            end
          end
          START: begin
            if (r_os_cnt == OS_HALF) begin
              r_os_cnt  <= '0;
              r_bit_cnt <= '0;
              if (!w_rxd_s) begin
                r_state <= DATA;
              end else begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_os_cnt <= r_os_cnt + OS_W'(1);
            end
          end
          DATA: begin
            if (r_os_cnt == OS_LAST) begin
              r_shift   <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
              r_os_cnt  <= '0;
              r_bit_cnt <= r_bit_cnt + BC_W'(1);
              if (r_bit_cnt == BC_LAST) r_state <= STOP;
            end else begin
              r_os_cnt <= r_os_cnt + OS_W'(1);
            end
          end
          STOP: begin
            if (r_os_cnt == OS_LAST) begin
              r_os_cnt <= '0;
              if (w_rxd_s) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_ferr  <= 1'b1;
                r_state <= WAIT_HI;
              end
            end else begin
              r_os_cnt <= r_os_cnt + OS_W'(1);
            end
          end
          WAIT_HI: begin
            if (w_rxd_s) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. It drives table-driven frames into a scoreboard and adds
// hand-written glitch and reset cases, plus a slow-divider instance.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_a = 1'b0, baud_b = 1'b0;
  logic       rxd_a = 1'b1, rxd_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic       dv_a, fe_a, busy_a, dv_b, fe_b, busy_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uart_rx #(.DATA_BITS(8), .OS_RATE(16), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .baud_x16(baud_a), .rxd(rxd_a),
    .data(data_a), .data_valid(dv_a), .frame_err(fe_a), .busy(busy_a));

  // Second instance: real 652-clk divider with a short oversample ratio to keep runtime bounded.
  uart_rx #(.DATA_BITS(8), .OS_RATE(4), .SYNC_STAGES(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .baud_x16(baud_b), .rxd(rxd_b),
    .data(data_b), .data_valid(dv_b), .frame_err(fe_b), .busy(busy_b));

  int cnt_a = 0, cnt_b = 0;
  always @(negedge clk) begin
    cnt_a = (cnt_a >= 7) ? 0 : cnt_a + 1;
    baud_a = (cnt_a == 0);
    cnt_b = (cnt_b >= 651) ? 0 : cnt_b + 1;
    baud_b = (cnt_b == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct { logic ferr; logic [7:0] d; } exp_t;
  exp_t       sb[$];
  logic [7:0] last_good = 8'h00;

  always @(negedge clk) begin
    if (rst_n && (dv_a || fe_a)) begin
      exp_t e;
      check("pulse_exclusive", {31'd0, dv_a & fe_a}, 32'd0);
      check("pulse_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pulse_kind", {31'd0, fe_a}, {31'd0, e.ferr});
        if (dv_a) begin
          check("rx_data", {24'd0, data_a}, {24'd0, e.d});
          last_good = e.d;
        end else begin
          check("data_held", {24'd0, data_a}, {24'd0, last_good});
        end
      end
    end
  end

  int         b_valid_cnt = 0, b_ferr_cnt = 0;
  logic [7:0] b_last = 8'h00;
  always @(negedge clk) begin
    if (rst_n && dv_b) begin
      b_valid_cnt++;
      b_last = data_b;
    end
    if (rst_n && fe_b) b_ferr_cnt++;
  end

  task automatic hold(input int which, input logic v, input int n);
    if (which == 0) rxd_a = v; else rxd_b = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int which, input logic [7:0] d, input logic stop, input int bit_clk);
    hold(which, 1'b0, bit_clk);
    for (int i = 0; i < 8; i++) hold(which, d[i], bit_clk);
    hold(which, stop, bit_clk);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         bit_clk;
    int         hold_lo_bits;
    int         gap_clk;
    logic       exp_ferr;
    logic       exp_busy_after;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'h55, 1'b1, 128, 0, 256, 1'b0, 1'b0};
    vecs[1] = '{8'hA3, 1'b1, 128, 0, 0,   1'b0, 1'b0};
    vecs[2] = '{8'h0F, 1'b1, 128, 0, 256, 1'b0, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 128, 3, 256, 1'b1, 1'b0};
    vecs[4] = '{8'h81, 1'b1, 128, 0, 256, 1'b0, 1'b0};
    vecs[5] = '{8'hC6, 1'b1, 124, 0, 256, 1'b0, 1'b0};
    vecs[6] = '{8'hC6, 1'b1, 132, 0, 256, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_data",  {24'd0, data_a}, 32'd0);
    check("rst_valid", {31'd0, dv_a},   32'd0);
    check("rst_ferr",  {31'd0, fe_a},   32'd0);
    check("rst_busy",  {31'd0, busy_a}, 32'd0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      sb.push_back('{vecs[i].exp_ferr, vecs[i].d});
      send(0, vecs[i].d, vecs[i].stop, vecs[i].bit_clk);
      if (vecs[i].hold_lo_bits > 0) hold(0, 1'b0, vecs[i].hold_lo_bits * vecs[i].bit_clk);
      if (vecs[i].gap_clk > 0) begin
        hold(0, 1'b1, vecs[i].gap_clk);
        check("busy_after_frame", {31'd0, busy_a}, {31'd0, vecs[i].exp_busy_after});
        check("sb_drained", sb.size(), 32'd0);
      end
    end

    // A start-bit glitch of 4 ticks must be rejected at the half-bit check.
    begin
      int busy_cnt = 0;
      rxd_a = 1'b0;
      for (int i = 0; i < 200; i++) begin
        if (i == 32) rxd_a = 1'b1;
        @(negedge clk);
        if (busy_a) busy_cnt++;
      end
      check("glitch_busy_seen", {31'd0, busy_cnt > 0}, 32'd1);
      check("glitch_busy_len",  {31'd0, busy_cnt <= 72}, 32'd1);
      check("glitch_busy_end",  {31'd0, busy_a}, 32'd0);
    end

    // Reset in the middle of bit 4 of 0xFF aborts the frame silently.
    hold(0, 1'b0, 128);
    for (int i = 0; i < 4; i++) hold(0, 1'b1, 128);
    hold(0, 1'b1, 64);
    rst_n = 1'b0;
    #1;
    check("midrst_data",  {24'd0, data_a}, 32'd0);
    check("midrst_valid", {31'd0, dv_a},   32'd0);
    check("midrst_ferr",  {31'd0, fe_a},   32'd0);
    check("midrst_busy",  {31'd0, busy_a}, 32'd0);
    last_good = 8'h00;
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    hold(0, 1'b1, 400);
    sb.push_back('{1'b0, 8'h12});
    send(0, 8'h12, 1'b1, 128);
    hold(0, 1'b1, 256);
    check("sb_final_empty", sb.size(), 32'd0);
    check("post_rst_data", {24'd0, data_a}, 32'h12);

    hold(1, 1'b1, 3000);
    send(1, 8'h7E, 1'b1, 4 * 652);
    hold(1, 1'b1, 3000);
    check("div652_valid_cnt", b_valid_cnt, 32'd1);
    check("div652_data", {24'd0, b_last}, 32'h7E);
    check("div652_ferr_cnt", b_ferr_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
